serial_store_collector: RTL and testbench
=========================================

Name: serial_store_collector

Overview:
Bit-serial store path for the bit-serial core. It collects an LSB-first operand bit stream (one bit per clock, indexed by bit position) and assembles it into a 32-bit word. It generates the byte-lane write mask from the access size and the low address bits, then queues the completed write in a small buffer. A req/ack handshake drains each buffered write to the block RAM port (data, 10-bit word address, 4-bit mask). It is the word-assembling counterpart of the load-side serialiser, and it lets the control unit stream store data without stalling on the memory port.

Parameters:
BUF_DEPTH, 2, number of buffered completed writes (power of two, >=2)
ADDR_W, 10, memory word-address width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a store frame; sampled only when frame_ready=1
func  input  3  access size: 000 byte, 001 half, 010 word; others illegal
byte_addr  input  ADDR_W+2  full byte address of the store, latched on start
frame_ready  output  1  collector idle and buffer has a free slot
bit_valid  input  1  bit_in/bit_pos are valid this cycle
bit_in  input  1  serial data bit, LSB first
bit_pos  input  6  position of bit_in (0..31)
busy  output  1  frame in progress (COLLECT state)
mem_req  output  1  buffer head valid
mem_ack  input  1  memory consumed head this cycle
mem_addr  output  ADDR_W  word address of head entry
mem_data  output  32  lane-aligned write data of head entry
mem_wr_mask  output  4  byte-enable mask of head entry
err  output  2  sticky: [0] misaligned/illegal func, [1] bit sequence error
err_clr  input  1  synchronous clear of err

Behaviour:
- Reset values:
  - state=IDLE, bit counter=0, assembly shift register=0.
  - Buffer empty: mem_req=0, mem_addr=0, mem_data=0, mem_wr_mask=0.
  - err=0, busy=0, frame_ready=1.
- frame_ready = (state==IDLE) && (occupancy<BUF_DEPTH).
  - start while frame_ready=0 is ignored, with no error.
- Frame start, start && frame_ready in IDLE:
  - Latch func, byte_addr[1:0] (off) and byte_addr[ADDR_W+1:2].
  - Width N = 8/16/32 for func 000/001/010.
  - Alignment check:
    - Illegal func, half with off[0]=1, or word with off!=0: set err[0]; state stays IDLE; nothing is queued.
    - Otherwise go to COLLECT with counter=0.
- COLLECT, bit_valid=1:
  - bit_pos must equal counter. On mismatch: set err[1], discard partial word, return to IDLE.
  - On match: store bit at word index counter+8*off, then counter++.
  - When the bit with bit_pos==N-1 is accepted, push an entry in the same edge and return to IDLE. frame_ready can rise the next cycle.
  - Entry contents: data = assembled word with unused lanes 0. mask = 0001<<off (byte), 0011<<off (half), 1111 (word).
  - Latency: last bit accepted at edge k, so mem_req=1 after edge k when the buffer was empty.
- COLLECT, bit_valid=0: hold; there is no timeout.
- start during COLLECT is ignored.
- Buffer behaviour:
  - FIFO with head outputs registered from storage.
  - mem_addr, mem_data and mem_wr_mask stay stable while mem_req=1 and mem_ack=0.
  - Pop on mem_req && mem_ack. mem_ack with mem_req=0 is ignored.
  - Push and pop in the same cycle: occupancy unchanged, order preserved. Pointers wrap modulo BUF_DEPTH.
  - Overflow is impossible: a frame starts only with a free slot, and pops only free slots.
- err is sticky until err_clr. If err_clr coincides with a new error event, the new error wins.
- Asynchronous reset mid-frame or with a non-empty buffer: all partial data and queued writes are discarded immediately and outputs return to reset values. No write is emitted.

Test Plan:
- Word store: byte_addr=0x010, func=010, stream 0xDEADBEEF LSB-first at pos 0..31 -> one cycle after pos 31, mem_req=1, mem_addr=0x004, mem_data=0xDEADBEEF, mask=1111; ack -> mem_req=0, frame_ready=1.
- Byte store: byte_addr=0x007, func=000, bits 0x5A at pos 0..7 -> mem_addr=0x001, mem_data=0x5A000000, mask=1000. Then half at 0x00A with 0xBEEF -> mem_data=0xBEEF0000, mask=1100.
- Misaligned: half at byte_addr=0x003 -> err=01, no mem_req, frame_ready stays 1. err_clr -> err=00.
- Sequence error: word store with pos 0,1,3 -> err[1]=1, back to IDLE, no entry queued.
- Buffer full with ack held low: two word stores (0x11111111 @0x0, 0x22222222 @0x4) -> frame_ready=0 and third start ignored. Ack 1 cycle -> head becomes 0x22222222 at addr 1, frame_ready=1. Simultaneous push/pop keeps order.
- Reset mid-frame after 12 bits and with 1 queued entry -> immediately mem_req=0, busy=0, err=0. The next full word store produces exactly one correct write.

Source files
------------

// File: rtl/serial_store_collector.sv
// serial_store_collector
//   Bit-serial store path. An LSB-first operand bit stream is assembled into
//   a lane-aligned 32-bit word. A byte-enable mask is built from the access
//   size and the low address bits. Each completed write is queued in a small
//   FIFO, and the FIFO is drained to the block RAM port over a req/ack
//   handshake.
//
// Handshakes:
//   start/frame_ready : a frame begins on a clock edge where start=1 and
//                       frame_ready=1. A start while frame_ready=0 is dropped.
//   mem_req/mem_ack   : mem_req is high while the FIFO head is valid. The head
//                       fields are held stable until an edge where
//                       mem_req=1 and mem_ack=1; that edge pops the head.
//                       mem_ack while mem_req=0 has no effect.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, func,        frame start, access size (000 byte / 001 half /
//   byte_addr           010 word), full byte address
//   frame_ready         idle and a FIFO slot is free
//   bit_valid, bit_in,  serial data bit and its bit position
//   bit_pos
//   busy                frame in progress (COLLECT)
//   mem_req, mem_ack    write request / consume
//   mem_addr, mem_data, head entry: word address, data, byte mask
//   mem_wr_mask
//   err, err_clr        sticky errors [0] align/func, [1] sequence; clear
module serial_store_collector #(
    parameter int BUF_DEPTH = 2,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        func,
    input  logic [ADDR_W+1:0] byte_addr,
    output logic              frame_ready,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic [5:0]        bit_pos,
    output logic              busy,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic [3:0]        mem_wr_mask,
    output logic [1:0]        err,
    input  logic              err_clr
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(BUF_DEPTH);

    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

    state_t state_q, state_d;

    // frame registers
    logic [5:0]        cnt_q, cnt_d;
    logic [5:0]        last_q, last_d;     // bit_pos of the final bit (N-1)
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [3:0]        mask_q, mask_d;
    logic [31:0]       shreg_q, shreg_d;
    logic [1:0]        err_q, err_d;

    // write buffer
    logic [31:0]       buf_data_q [BUF_DEPTH];
    logic [31:0]       buf_data_d [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_addr_q [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_addr_d [BUF_DEPTH];
    logic [3:0]        buf_mask_q [BUF_DEPTH];
    logic [3:0]        buf_mask_d [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    // decode
    logic       align_ok;
    logic       frame_go;
    logic       frame_bad;
    logic       bit_take;
    logic       seq_err;
    logic       bit_acc;
    logic       last_bit;
    logic [4:0] bit_idx;
    logic       push;
    logic       pop;

    always_comb begin
        unique case (func)
            3'b000:  align_ok = 1'b1;
            3'b001:  align_ok = ~byte_addr[0];
            3'b010:  align_ok = (byte_addr[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
        frame_go  = start && frame_ready && align_ok;
        frame_bad = start && frame_ready && !align_ok;
        bit_take  = (state_q == COLLECT) && bit_valid;
        seq_err   = bit_take && (bit_pos != cnt_q);
        bit_acc   = bit_take && (bit_pos == cnt_q);
        last_bit  = bit_acc && (cnt_q == last_q);
        // Bits land directly in their byte lane, so the word is lane-aligned.
        bit_idx   = cnt_q[4:0] + {off_q, 3'b000};
        push      = last_bit;
        pop       = mem_req && mem_ack;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_go) state_d = COLLECT;
            COLLECT: if (seq_err || last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy        = (state_q == COLLECT);
        frame_ready = (state_q == IDLE) && (count_q < DEPTH_C);
        mem_req     = (count_q != '0);
        mem_addr    = buf_addr_q[rd_ptr_q];
        mem_data    = buf_data_q[rd_ptr_q];
        mem_wr_mask = buf_mask_q[rd_ptr_q];
        err         = err_q;
    end

    // ---------------- frame datapath ----------------
    always_comb begin
        cnt_d   = cnt_q;
        last_d  = last_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        mask_d  = mask_q;
        shreg_d = shreg_q;
        if (frame_go) begin
            cnt_d   = 6'd0;
            off_d   = byte_addr[1:0];
            waddr_d = byte_addr[ADDR_W+1:2];
            shreg_d = 32'd0;
            unique case (func)
                3'b000: begin last_d = 6'd7;  mask_d = 4'b0001 << byte_addr[1:0]; end
                3'b001: begin last_d = 6'd15; mask_d = 4'b0011 << byte_addr[1:0]; end
                default: begin last_d = 6'd31; mask_d = 4'b1111; end
            endcase
        end
        if (seq_err) begin
            shreg_d = 32'd0;
            cnt_d   = 6'd0;
        end
        if (bit_acc) begin
            shreg_d[bit_idx] = bit_in;
            cnt_d            = cnt_q + 6'd1;
        end
    end

    // A new error in the same cycle as err_clr survives the clear.
    always_comb begin
        err_d = err_clr ? 2'b00 : err_q;
        if (frame_bad) err_d[0] = 1'b1;
        if (seq_err)   err_d[1] = 1'b1;
    end

    // ---------------- write buffer ----------------
    always_comb begin
        buf_data_d = buf_data_q;
        buf_addr_d = buf_addr_q;
        buf_mask_d = buf_mask_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            // shreg_d already holds the final bit taken this cycle
            buf_data_d[wr_ptr_q] = shreg_d;
            buf_addr_d[wr_ptr_q] = waddr_q;
            buf_mask_d[wr_ptr_q] = mask_q;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            last_q     <= '0;
            off_q      <= '0;
            waddr_q    <= '0;
            mask_q     <= '0;
            shreg_q    <= '0;
            err_q      <= '0;
            buf_data_q <= '{default: '0};
            buf_addr_q <= '{default: '0};
            buf_mask_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            off_q      <= off_d;
            waddr_q    <= waddr_d;
            mask_q     <= mask_d;
            shreg_q    <= shreg_d;
            err_q      <= err_d;
            buf_data_q <= buf_data_d;
            buf_addr_q <= buf_addr_d;
            buf_mask_q <= buf_mask_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_serial_store_collector.sv
// Directed testbench for serial_store_collector.
module tb_serial_store_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  func = 3'b000;
    logic [11:0] byte_addr = 12'h000;
    logic        frame_ready;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic [5:0]  bit_pos = 6'd0;
    logic        busy;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_wr_mask;
    logic [1:0]  err;
    logic        err_clr = 1'b0;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    serial_store_collector #(.BUF_DEPTH(2), .ADDR_W(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .func        (func),
        .byte_addr   (byte_addr),
        .frame_ready (frame_ready),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .bit_pos     (bit_pos),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wr_mask (mem_wr_mask),
        .err         (err),
        .err_clr     (err_clr)
    );

    // clock
    always #5 clk = ~clk;

    // outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [2:0] f, input logic [11:0] a);
        start     = 1'b1;
        func      = f;
        byte_addr = a;
        tick();
        start     = 1'b0;
    endtask

    // Sends bits 0..n-1 of v. gap inserts idle cycles after bit 3;
    // ack_last raises mem_ack together with the final bit.
    task automatic send_bits(input logic [31:0] v, input int n, input bit gap, input bit ack_last);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_in    = v[i];
            bit_pos   = 6'(i);
            mem_ack   = (i == n - 1) ? ack_last : 1'b0;
            tick();
            if (gap && i == 3) begin
                bit_valid = 1'b0;
                repeat (3) tick();
            end
        end
        bit_valid = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic ack_once();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        // ---- reset ----
        repeat (2) tick();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_mask", {28'd0, mem_wr_mask}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_ready", {31'd0, frame_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // ---- word store 0xDEADBEEF @ 0x010 ----
        start_frame(3'b010, 12'h010);
        chk("word_busy", {31'd0, busy}, 32'd1);
        chk("word_fr_low", {31'd0, frame_ready}, 32'd0);
        send_bits(32'hDEADBEEF, 32, 1'b0, 1'b0);
        chk("word_req", {31'd0, mem_req}, 32'd1);
        chk("word_addr", {22'd0, mem_addr}, 32'h004);
        chk("word_data", mem_data, 32'hDEADBEEF);
        chk("word_mask", {28'd0, mem_wr_mask}, 32'hF);
        chk("word_busy_done", {31'd0, busy}, 32'd0);
        ack_once();
        chk("word_req_after_ack", {31'd0, mem_req}, 32'd0);
        chk("word_fr_after_ack", {31'd0, frame_ready}, 32'd1);

        // ---- byte 0x5A @ 0x007 ----
        start_frame(3'b000, 12'h007);
        send_bits(32'h0000005A, 8, 1'b0, 1'b0);
        chk("byte_req", {31'd0, mem_req}, 32'd1);
        chk("byte_addr", {22'd0, mem_addr}, 32'h001);
        chk("byte_data", mem_data, 32'h5A000000);
        chk("byte_mask", {28'd0, mem_wr_mask}, 32'h8);
        ack_once();

        // ---- half 0xBEEF @ 0x00A ----
        start_frame(3'b001, 12'h00A);
        send_bits(32'h0000BEEF, 16, 1'b0, 1'b0);
        chk("half_addr", {22'd0, mem_addr}, 32'h002);
        chk("half_data", mem_data, 32'hBEEF0000);
        chk("half_mask", {28'd0, mem_wr_mask}, 32'hC);
        ack_once();
        chk("half_req_after_ack", {31'd0, mem_req}, 32'd0);

        // ---- misaligned half @ 0x003 ----
        start_frame(3'b001, 12'h003);
        chk("misal_err", {30'd0, err}, 32'd1);
        chk("misal_busy", {31'd0, busy}, 32'd0);
        chk("misal_req", {31'd0, mem_req}, 32'd0);
        chk("misal_fr", {31'd0, frame_ready}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("misal_clr", {30'd0, err}, 32'd0);

        // ---- sequence error: pos 0,1,3 ----
        start_frame(3'b010, 12'h000);
        send_bits(32'h00000003, 2, 1'b0, 1'b0);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        bit_pos   = 6'd3;
        tick();
        bit_valid = 1'b0;
        chk("seq_err", {30'd0, err}, 32'd2);
        chk("seq_busy", {31'd0, busy}, 32'd0);
        chk("seq_req", {31'd0, mem_req}, 32'd0);
        chk("seq_fr", {31'd0, frame_ready}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("seq_clr", {30'd0, err}, 32'd0);

        // ---- buffer full, ack held low (first frame has an idle gap) ----
        start_frame(3'b010, 12'h000);
        send_bits(32'h11111111, 32, 1'b1, 1'b0);
        chk("full1_data", mem_data, 32'h11111111);
        chk("full1_fr", {31'd0, frame_ready}, 32'd1);
        start_frame(3'b010, 12'h004);
        send_bits(32'h22222222, 32, 1'b0, 1'b0);
        chk("full2_fr", {31'd0, frame_ready}, 32'd0);
        chk("full2_head_data", mem_data, 32'h11111111);
        chk("full2_head_addr", {22'd0, mem_addr}, 32'h000);
        start_frame(3'b010, 12'h008);
        chk("full3_ignored", {31'd0, busy}, 32'd0);
        tick();
        chk("full_hold_data", mem_data, 32'h11111111);
        ack_once();
        chk("pop_data", mem_data, 32'h22222222);
        chk("pop_addr", {22'd0, mem_addr}, 32'h001);
        chk("pop_fr", {31'd0, frame_ready}, 32'd1);
        chk("pop_req", {31'd0, mem_req}, 32'd1);

        // ---- push and pop on the same edge ----
        start_frame(3'b010, 12'h00C);
        send_bits(32'h33333333, 32, 1'b0, 1'b1);
        chk("pp_data", mem_data, 32'h33333333);
        chk("pp_addr", {22'd0, mem_addr}, 32'h003);
        chk("pp_fr", {31'd0, frame_ready}, 32'd1);
        ack_once();
        chk("pp_drained", {31'd0, mem_req}, 32'd0);

        // ---- reset mid-frame with one queued entry and err set ----
        start_frame(3'b010, 12'h000);
        send_bits(32'h44444444, 32, 1'b0, 1'b0);
        start_frame(3'b011, 12'h000);
        chk("pre_rst_err", {30'd0, err}, 32'd1);
        start_frame(3'b010, 12'h020);
        send_bits(32'h0000ABCD, 12, 1'b0, 1'b0);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, mem_req}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_err", {30'd0, err}, 32'd0);
        chk("arst_data", mem_data, 32'd0);
        chk("arst_fr", {31'd0, frame_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        start_frame(3'b010, 12'h040);
        send_bits(32'hCAFEF00D, 32, 1'b0, 1'b0);
        chk("post_rst_req", {31'd0, mem_req}, 32'd1);
        chk("post_rst_addr", {22'd0, mem_addr}, 32'h010);
        chk("post_rst_data", mem_data, 32'hCAFEF00D);
        chk("post_rst_mask", {28'd0, mem_wr_mask}, 32'hF);
        ack_once();
        chk("post_rst_single", {31'd0, mem_req}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
